// File: rtl/nv_ram_rws_gen.sv
// nv_ram_rws_gen: parametrised 1R1W synchronous RAM model with byte-lane mask, collision policy, optional output register and clear sweep
// Ports:
//   clk, rst            core clock, asynchronous active-high reset
//   ra, re              read address / read enable
//   dout, dout_vld      read data and its one-cycle valid pulse (latency OUT_REG+1)
//   wa, we, wmask, di   write address / enable / byte-lane mask / data
//   clr_req             request a full-array zero sweep (taken only when idle)
//   busy                sweep in progress; reads and writes are dropped
//   pwrbus_ram_pd       power-bus control, no functional effect
module nv_ram_rws_gen #(
    parameter int DEPTH      = 128,
    parameter int AW         = 7,
    parameter int DW         = 512,
    parameter int MW         = DW / 8,
    parameter int OUT_REG    = 0,
    parameter int BYPASS     = 1,
    parameter int CLR_ON_RST = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra,
    input  logic          re,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    input  logic [AW-1:0] wa,
    input  logic          we,
    input  logic [MW-1:0] wmask,
    input  logic [DW-1:0] di,
    input  logic          clr_req,
    output logic          busy,
    input  logic [31:0]   pwrbus_ram_pd
);
    typedef enum logic {IDLE, CLR} state_t;
    state_t state, state_nxt;
    logic [AW-1:0] clr_cnt;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] wbits, rd_old, rd_data, dout_q;
    logic vld_q, rd_go, wr_go, unused_pd;

    if (DW % 8 != 0 || 2 ** AW != DEPTH) begin : g_chk
        $error("nv_ram_rws_gen: DW must be a multiple of 8 and DEPTH must equal 2**AW");
    end

    for (genvar i = 0; i < MW; i++) begin : g_lane
        assign wbits[8*i +: 8] = {8{wmask[i]}};
    end

    assign unused_pd = ^pwrbus_ram_pd;
    assign busy      = state == CLR;
    assign rd_go     = state == IDLE && re;
    assign wr_go     = state == IDLE && we;
    assign rd_old    = mem[ra];
    // Bypass merges only the lanes being written; unmasked lanes keep the stored value.
    assign rd_data   = (BYPASS != 0 && wr_go && ra == wa) ? (di & wbits) | (rd_old & ~wbits) : rd_old;

    always_comb begin
        state_nxt = state == IDLE ? (clr_req ? CLR : IDLE) : (clr_cnt == AW'(DEPTH - 1) ? IDLE : CLR);
    end

    always_ff @(posedge clk) begin
        if (state == CLR) mem[clr_cnt] <= '0;
        else if (wr_go) mem[wa] <= (di & wbits) | (mem[wa] & ~wbits);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLR_ON_RST != 0 ? CLR : IDLE;
            clr_cnt <= '0;
            dout_q  <= '0;
            vld_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= state == CLR ? clr_cnt + 1'b1 : '0;
            vld_q   <= rd_go;
            if (rd_go) dout_q <= rd_data;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DW-1:0] dout_r;
        logic          vld_r;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_r <= '0;
                vld_r  <= 1'b0;
            end else begin
                vld_r <= vld_q;
                if (vld_q) dout_r <= dout_q;
            end
        end
        assign dout     = dout_r;
        assign dout_vld = vld_r;
    end else begin : g_noreg
        assign dout     = dout_q;
        assign dout_vld = vld_q;
    end
endmodule

// File: tb/tb_nv_ram_rws_gen.sv
// tb_nv_ram_rws_gen: self-checking bench for nv_ram_rws_gen (default instance plus OUT_REG=1/BYPASS=0 instance)
module tb_nv_ram_rws_gen;
    localparam int DW = 512;
    localparam int MW = 64;

    logic clk = 0, rst = 1, re = 0, we = 0, clr_req = 0;
    logic [6:0] ra = 0, wa = 0;
    logic [MW-1:0] wmask = 0;
    logic [DW-1:0] di = 0, dout0, dout1;
    logic vld0, vld1, busy0, busy1;
    logic [31:0] pd = 32'h0;

    always #5 clk = ~clk;

    nv_ram_rws_gen u0 (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout0), .dout_vld(vld0),
        .wa(wa), .we(we), .wmask(wmask), .di(di), .clr_req(clr_req), .busy(busy0), .pwrbus_ram_pd(pd)
    );

    nv_ram_rws_gen #(.OUT_REG(1), .BYPASS(0)) u1 (
        .clk(clk), .rst(rst), .ra(ra), .re(re), .dout(dout1), .dout_vld(vld1),
        .wa(wa), .we(we), .wmask(wmask), .di(di), .clr_req(clr_req), .busy(busy1), .pwrbus_ram_pd(pd)
    );

    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } exp_t;

    typedef struct {
        logic          r;
        logic [6:0]    ar;
        logic          w;
        logic [6:0]    aw;
        logic [MW-1:0] m;
        logic [DW-1:0] d;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
    } vec_t;

    exp_t q0[$], q1[$];
    vec_t tv[$];
    int ncmp = 0, nerr = 0, cyc = 0, bcnt = 0;
    logic mbusy = 1, rst_v = 1;
    logic [6:0] mcnt = 0;
    logic [DW-1:0] last0 = '0, last1 = '0;
    logic [DW-1:0] ff, a, b, c, d, p0, p1, p2, m3, ln, mrg;
    logic [MW-1:0] fm;

    task automatic cmp(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%h want=%h", n, cyc, act, exp);
        end
    endtask

    task automatic check();
        logic e0v, e1v;
        e0v = q0.size() > 0 && q0[0].due == cyc;
        e1v = q1.size() > 0 && q1[0].due == cyc;
        if (e0v) begin last0 = q0[0].d; q0.delete(0); end
        if (e1v) begin last1 = q1[0].d; q1.delete(0); end
        if (busy0) bcnt++;
        cmp("busy0", busy0, mbusy);
        cmp("busy1", busy1, mbusy);
        cmp("vld0", vld0, e0v);
        cmp("vld1", vld1, e1v);
        cmp("dout0", dout0, last0);
        cmp("dout1", dout1, last1);
    endtask

    task automatic step(input logic r, input logic [6:0] ar_i, input logic w, input logic [6:0] aw_i,
                        input logic [MW-1:0] m, input logic [DW-1:0] dv, input logic cl,
                        input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        @(negedge clk);
        check();
        rst = rst_v; re = r; ra = ar_i; we = w; wa = aw_i; wmask = m; di = dv; clr_req = cl;
        if (rst_v) begin
            mbusy = 1; mcnt = 0; last0 = '0; last1 = '0;
            q0.delete(); q1.delete();
        end else if (mbusy) begin
            mcnt++;
            if (mcnt == 0) mbusy = 0;
        end else begin
            if (r) begin
                q0.push_back('{cyc + 1, e0});
                q1.push_back('{cyc + 2, e1});
            end
            if (cl) mbusy = 1;
        end
        cyc++;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, '0, '0, 0, '0, '0);
    endtask

    task automatic rd(input logic [6:0] ad, input logic [DW-1:0] e);
        step(1, ad, 0, 0, '0, '0, 0, e, e);
    endtask

    task automatic wr(input logic [6:0] ad, input logic [DW-1:0] dv);
        step(0, 0, 1, ad, fm, dv, 0, '0, '0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && mbusy; i++) idle();
        idle();
    endtask

    initial begin
        ff = '1; fm = '1;
        a = {64{8'hA5}}; b = {64{8'h5A}}; c = {64{8'h3C}}; d = {64{8'hD2}};
        p0 = {64{8'h11}}; p1 = {64{8'h22}}; p2 = {64{8'h33}};
        m3 = {{63{8'hFF}}, 8'h00};
        ln = {384'd0, {64{1'b1}}, 64'd0};
        mrg = (b & ~ln) | (c & ln);

        tv.push_back('{0, 0, 1, 3, fm, ff, '0, '0});
        tv.push_back('{0, 0, 1, 3, 64'h1, '0, '0, '0});
        tv.push_back('{1, 3, 0, 0, '0, '0, m3, m3});
        tv.push_back('{0, 0, 1, 10, fm, a, '0, '0});
        tv.push_back('{1, 10, 1, 10, fm, b, b, a});
        tv.push_back('{1, 10, 0, 0, '0, '0, b, b});
        tv.push_back('{1, 10, 1, 10, 64'hFF00, c, mrg, b});
        tv.push_back('{1, 10, 0, 0, '0, '0, mrg, mrg});
        tv.push_back('{1, 3, 1, 4, fm, d, m3, m3});
        tv.push_back('{1, 4, 0, 0, '0, '0, d, d});
        tv.push_back('{0, 0, 1, 4, '0, a, '0, '0});
        tv.push_back('{1, 4, 0, 0, '0, '0, d, d});
        tv.push_back('{0, 0, 1, 0, fm, p0, '0, '0});
        tv.push_back('{0, 0, 1, 1, fm, p1, '0, '0});
        tv.push_back('{0, 0, 1, 2, fm, p2, '0, '0});
        tv.push_back('{1, 0, 0, 0, '0, '0, p0, p0});
        tv.push_back('{1, 1, 0, 0, '0, '0, p1, p1});
        tv.push_back('{1, 2, 0, 0, '0, '0, p2, p2});
        tv.push_back('{1, 3, 0, 0, '0, '0, m3, m3});

        repeat (3) idle();
        rst_v = 0;
        bcnt = 0;
        wait_idle();
        cmp("sweep_len_after_reset", 32'(bcnt), 32'd128);
        rd(5, '0);

        for (int i = 0; i < tv.size(); i++)
            step(tv[i].r, tv[i].ar, tv[i].w, tv[i].aw, tv[i].m, tv[i].d, 0, tv[i].e0, tv[i].e1);
        repeat (4) idle();

        wr(7, a);
        bcnt = 0;
        step(1, 3, 1, 7, fm, b, 1, m3, m3);
        repeat (5) step(1, 7, 1, 7, fm, c, 1, '0, '0);
        wait_idle();
        cmp("sweep_len_on_req", 32'(bcnt), 32'd128);
        rd(7, '0);
        rd(3, '0);
        idle();

        wr(100, a);
        rd(100, a);
        step(0, 0, 0, 0, '0, '0, 1, '0, '0);
        repeat (60) idle();
        rst_v = 1;
        repeat (2) idle();
        rst_v = 0;
        bcnt = 0;
        wait_idle();
        cmp("sweep_len_after_mid_rst", 32'(bcnt), 32'd128);
        rd(100, '0);
        repeat (3) idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
